// File: rtl/redmule_z_pingpong.sv
// redmule_z_pingpong: two-bank Z row collector that drains completed tiles as a valid/ready stream with a per-tile byte strobe
// Ports: clk_i/rst_i/clear_i (sync, active-high); in_valid_i/in_data_i/in_ready_o row input;
//   cfg_rows_i/cfg_strb_i tile shape, latched on the first row of a bank;
//   z_valid_o/z_data_o/z_strb_o/z_ready_i beat output; tile_done_o last-beat pulse; busy_o; perf_stall_o.
// Build option: define REDMULE_ZBUF_PERF_EN to enable the saturating stall counter on perf_stall_o.
module redmule_z_pingpong #(
  parameter int DW    = 256,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  input  logic [DW-1:0]              in_data_i,
  output logic                       in_ready_o,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_rows_i,
  input  logic [DW/8-1:0]            cfg_strb_i,
  output logic                       z_valid_o,
  output logic [DW-1:0]              z_data_o,
  output logic [DW/8-1:0]            z_strb_o,
  input  logic                       z_ready_i,
  output logic                       tile_done_o,
  output logic                       busy_o,
  output logic [31:0]                perf_stall_o
);
  localparam int RW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;
  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic [DW-1:0] mem [2][DEPTH];
  logic [RW-1:0] rows_q [2];
  logic [DW/8-1:0] strb_q [2];
  logic wr_bank, rd_bank;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [RW-1:0] cfg_rows, wr_rows;
  logic wr_fire, rd_fire, wr_last, rd_last, wr_first;
  logic soft_rst;
  assign soft_rst = rst_i | clear_i;
  assign cfg_rows = (cfg_rows_i == '0 || cfg_rows_i > RW'(DEPTH)) ? RW'(DEPTH) : cfg_rows_i;
  assign wr_first = state_q[wr_bank] == EMPTY;
  // the first row of a tile sees the live config, later rows the latched count
  assign wr_rows = wr_first ? cfg_rows : rows_q[wr_bank];
  assign in_ready_o = state_q[wr_bank] != FULL;
  assign wr_fire = in_valid_i & in_ready_o;
  assign wr_last = RW'(wr_ptr) == wr_rows - RW'(1);
  assign z_valid_o = state_q[rd_bank] == FULL;
  assign z_data_o = mem[rd_bank][rd_ptr];
  assign z_strb_o = strb_q[rd_bank];
  assign rd_fire = z_valid_o & z_ready_i;
  assign rd_last = RW'(rd_ptr) == rows_q[rd_bank] - RW'(1);
  assign tile_done_o = rd_fire & rd_last;
  assign busy_o = state_q[0] != EMPTY || state_q[1] != EMPTY;
  // a write needs a non-FULL bank and a read a FULL one, so they never hit the same bank
  always_comb begin
    state_d = state_q;
    if (wr_fire) state_d[wr_bank] = wr_last ? FULL : FILLING;
    if (tile_done_o) state_d[rd_bank] = EMPTY;
  end
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (wr_fire) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + PW'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_ptr <= rd_last ? '0 : rd_ptr + PW'(1);
        if (rd_last) rd_bank <= ~rd_bank;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_bank][wr_ptr] <= in_data_i;
      if (wr_first) begin
        rows_q[wr_bank] <= cfg_rows;
        strb_q[wr_bank] <= cfg_strb_i;
      end
    end
  end
`ifdef REDMULE_ZBUF_PERF_EN
  logic [31:0] perf_q;
  logic [1:0] perf_inc;
  logic [32:0] perf_sum;
  assign perf_inc = 2'(z_valid_o & ~z_ready_i) + 2'(in_valid_i & ~in_ready_o);
  assign perf_sum = {1'b0, perf_q} + 33'(perf_inc);
  always_ff @(posedge clk_i) begin
    if (soft_rst) perf_q <= '0;
    else perf_q <= perf_sum[32] ? '1 : perf_sum[31:0];
  end
  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif
endmodule
